// File: rtl/apb_cmd_sequencer.sv
// APB master that replays queued write/read/poll commands and returns one response per command.
// Optional APB_PSLVERR_EN adds a PSLVERR input that terminates the current command with rsp_err.
`timescale 1ns/1ps
module apb_cmd_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 8,
  parameter int POLL_GAP   = 4,
  parameter int MAX_POLLS  = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [2:0]            state_dbg,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
`ifdef APB_PSLVERR_EN
  input  logic                  PSLVERR,
`endif
  input  logic                  PREADY
);

  localparam int PW  = $clog2(CMD_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GW  = $clog2(POLL_GAP + 1);
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t state, state_d;

  logic [1:0]            op_mem   [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] mask_mem [CMD_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic [1:0]            cur_op;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data, cur_mask;
  logic [PCW-1:0]        poll_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic push, pop, xfer_done, is_poll, poll_match, poll_last, slv_err;

  assign push = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state;
    pop        = 1'b0;
    xfer_done  = (state == S_ACCESS) && PREADY;
    is_poll    = (cur_op == OP_POLL);
    poll_match = ((PRDATA ^ cur_data) & cur_mask) == '0;
    poll_last  = (poll_cnt + 1'b1) == PCW'(MAX_POLLS);
`ifdef APB_PSLVERR_EN
    slv_err    = PSLVERR;
`else
    slv_err    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (!is_poll || slv_err || poll_match || poll_last) state_d = S_RESP;
          else                                                state_d = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (gap_cnt == GW'(POLL_GAP - 1)) state_d = S_SETUP;
      S_RESP:      if (rsp_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  // Command storage is unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
      mask_mem[wr_ptr] <= cmd_mask;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_op     <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      cur_mask   <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (pop) begin
        cur_op   <= op_mem[rd_ptr];
        cur_addr <= addr_mem[rd_ptr];
        cur_data <= data_mem[rd_ptr];
        cur_mask <= mask_mem[rd_ptr];
        poll_cnt <= '0;
      end
      if (xfer_done) begin
        rsp_data_q <= (cur_op == OP_WRITE) ? '0 : PRDATA;
        rsp_err_q  <= slv_err || (is_poll && !poll_match && poll_last);
        gap_cnt    <= '0;
        if (is_poll && !poll_match) poll_cnt <= poll_cnt + 1'b1;
      end
      if (state == S_POLL_WAIT) gap_cnt <= gap_cnt + 1'b1;
      if (state == S_RESP && rsp_ready) poll_cnt <= '0;
    end
  end

  assign cmd_ready = (count != CW'(CMD_DEPTH));
  assign busy      = (count != '0) || (state != S_IDLE);
  assign state_dbg = state;
  assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
  assign PENABLE   = (state == S_ACCESS);
  assign PADDR     = PSEL ? cur_addr : '0;
  assign PWRITE    = PSEL && (cur_op == OP_WRITE);
  assign PWDATA    = PWRITE ? cur_data : '0;
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign rsp_err   = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer: behavioural APB slave, response scoreboard, summary report.
`timescale 1ns/1ps
module tb_apb_cmd_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int MAXP  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [2:0]    state_dbg;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
`ifdef APB_PSLVERR_EN
  logic          PSLVERR = 1'b0;
`endif

  apb_cmd_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .POLL_GAP(GAP), .MAX_POLLS(MAXP)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .state_dbg(state_dbg),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA),
`ifdef APB_PSLVERR_EN
    .PSLVERR(PSLVERR),
`endif
    .PREADY(PREADY)
  );

  // behavioural APB slave
  int slv_waits = 0;
  int acc_cnt = 0;
  int poll_reads = 0;
  int poll_base = 0;
  int poll_rise = 1000;

  assign PREADY = (acc_cnt >= slv_waits);

  always_comb begin
    if (PADDR == 8'h08)      PRDATA = 32'hDEAD_BEEF;
    else if (PADDR == 8'h0C) PRDATA = ((poll_reads - poll_base + 1) >= poll_rise) ? 32'h0000_1231 : 32'h0000_1230;
    else                     PRDATA = 32'hC0DE_0000 | {24'h0, PADDR};
  end

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && !PWRITE && PADDR == 8'h0C) poll_reads <= poll_reads + 1;
  end

  // idle-gap monitor: PSEL-low cycles before the latest transfer start
  int idle_cnt = 0;
  int last_gap = 0;
  logic psel_q = 1'b0;
  always @(negedge clk) begin
    psel_q <= PSEL;
    if (PSEL && !psel_q) begin
      last_gap <= idle_cnt;
      idle_cnt <= 0;
    end else if (!PSEL) begin
      idle_cnt <= idle_cnt + 1;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("push_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    logic [DW:0] exp;
    int n;
    exp = exp_q.pop_front();
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check(tag, 64'({rsp_err, rsp_data}), 64'(exp));
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic stable;
    logic seen;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_psel_pen", 64'({PSEL, PENABLE}), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_state", 64'(state_dbg), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // write 0x04 <- 1, zero wait states
    push_cmd(2'd0, 8'h04, 32'h0000_0001, 32'h0);
    check("wr_idle_busy", 64'({PSEL, busy}), 64'b01);
    @(negedge clk);
    check("wr_setup_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'b101);
    check("wr_setup_addr", 64'(PADDR), 64'h04);
    check("wr_setup_wdata", 64'(PWDATA), 64'h1);
    @(negedge clk);
    check("wr_access_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'b111);
    check("wr_access_wdata", 64'(PWDATA), 64'h1);
    @(negedge clk);
    check("wr_resp_ctl", 64'({PSEL, PENABLE, rsp_valid}), 64'b001);
    check("wr_resp_paddr", 64'(PADDR), 64'h0);
    exp_q.push_back({1'b0, 32'h0});
    get_rsp("wr_rsp");

    // read 0x08 with 3 wait states
    slv_waits = 3;
    push_cmd(2'd1, 8'h08, 32'h1234_5678, 32'h0);
    @(negedge clk);
    check("rd_setup_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'b100);
    check("rd_setup_wdata", 64'(PWDATA), 64'h0);
    @(negedge clk);
    acc = 0;
    stable = 1'b1;
    while (PSEL && PENABLE && acc < 20) begin
      acc++;
      if (PADDR != 8'h08) stable = 1'b0;
      @(negedge clk);
    end
    check("rd_access_cycles", 64'(acc), 64'd4);
    check("rd_paddr_stable", 64'(stable), 64'd1);
    slv_waits = 0;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    get_rsp("rd_rsp");

    // poll 0x0C, bit0 rises on the 3rd read; bits outside mask differ
    poll_base = poll_reads;
    poll_rise = 3;
    push_cmd(2'd2, 8'h0C, 32'hFFFF_FFF1, 32'h0000_0001);
    exp_q.push_back({1'b0, 32'h0000_1231});
    get_rsp("poll_rsp");
    check("poll_reads", 64'(poll_reads - poll_base), 64'd3);
    check("poll_gap", 64'(last_gap), 64'd4);

    // poll that never matches: MAX_POLLS reads then timeout
    poll_base = poll_reads;
    poll_rise = 1000;
    push_cmd(2'd2, 8'h0C, 32'h0000_0001, 32'h0000_0001);
    exp_q.push_back({1'b1, 32'h0000_1230});
    get_rsp("poll_to_rsp");
    check("poll_to_reads", 64'(poll_reads - poll_base), 64'd4);

    // reserved opcode behaves as a read
    push_cmd(2'd3, 8'h30, 32'h0000_ABCD, 32'h0);
    @(negedge clk);
    check("op3_setup_ctl", 64'({PSEL, PWRITE, PWDATA}), 64'({1'b1, 1'b0, 32'h0}));
    exp_q.push_back({1'b0, 32'hC0DE_0030});
    get_rsp("op3_rsp");

    // fill: 9 commands while responses are blocked
    rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_cmd((i % 2 == 1) ? 2'd1 : 2'd0, 8'(8'h20 + i), 32'h100 + i, 32'h0);
      if (i % 2 == 1) exp_q.push_back({1'b0, 32'hC0DE_0000 | (32'h20 + i)});
      else            exp_q.push_back({1'b0, 32'h0});
    end
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    check("full_busy_state", 64'({busy, state_dbg}), 64'({1'b1, 3'd4}));
    for (int i = 0; i < 9; i++) get_rsp($sformatf("fifo_rsp%0d", i));
    check("drain_cmd_ready", 64'({cmd_ready, busy}), 64'b10);

    // reset asserted during a stalled ACCESS
    slv_waits = 5;
    push_cmd(2'd1, 8'h08, 32'h0, 32'h0);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_in_access", 64'({PSEL, PENABLE}), 64'b11);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_apb", 64'({PSEL, PENABLE}), 64'b00);
    check("rst_mid_busy", 64'({busy, rsp_valid}), 64'b00);
    @(negedge clk);
    resetn = 1'b1;
    slv_waits = 0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    check("rst_mid_no_rsp", 64'(seen), 64'd0);
    push_cmd(2'd0, 8'h10, 32'h0000_0055, 32'h0);
    push_cmd(2'd1, 8'h10, 32'h0, 32'h0);
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hC0DE_0010});
    get_rsp("post_rst_wr");
    get_rsp("post_rst_rd");

`ifdef APB_PSLVERR_EN
    PSLVERR = 1'b1;
    push_cmd(2'd0, 8'h40, 32'h0000_0077, 32'h0);
    exp_q.push_back({1'b1, 32'h0});
    get_rsp("slverr_wr");
    PSLVERR = 1'b0;
    check("slverr_idle", 64'(busy), 64'd0);
`endif

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
